// File: rtl/flash_read_arbiter.sv
// Two-port round-robin SPI (mode 0) read engine: each grant issues one READ (0x03)
// with a word-aligned 24-bit address and returns one little-endian 32-bit word.
module flash_read_arbiter #(
  parameter int CLK_DIV  = 2,
  parameter int CSB_IDLE = 2
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  output logic        req0_ack,
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  output logic        req1_ack,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CSB_IDLE > 1) ? $clog2(CSB_IDLE) : 1;
  localparam logic [HW-1:0] HALF_TC = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_TC  = GW'(CSB_IDLE - 1);
  localparam logic [7:0] CMD_READ = 8'h03;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;
  state_t r_state, w_state_next;

  logic          r_last, r_port, r_sclk, r_csb, r_ack0, r_ack1, r_busy;
  logic [HW-1:0] r_hcnt;
  logic [6:0]    r_half;
  logic [GW-1:0] r_gcnt;
  logic [31:0]   r_tx, r_rx, r_rdata;

  logic          w_grant, w_grant_port, w_half_tc, w_rise, w_fall, w_xfer_done, w_gap_done;
  logic [23:0]   w_grant_addr;
  logic [31:0]   w_word;

  // First byte on the wire lands in rdata[7:0].
  for (genvar gi = 0; gi < 4; gi++) begin : g_swap
    assign w_word[8*gi +: 8] = r_rx[31-8*gi -: 8];
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant)     w_state_next = S_XFER;
      S_XFER:  if (w_xfer_done) w_state_next = S_GAP;
      S_GAP:   if (w_gap_done)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant      = 1'b0;
    w_grant_port = 1'b0;
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    w_xfer_done  = 1'b0;
    w_gap_done   = 1'b0;
    w_half_tc    = (r_hcnt == HALF_TC);
    case (r_state)
      S_IDLE: begin
        w_grant      = req0_valid | req1_valid;
        w_grant_port = (req0_valid && req1_valid) ? ~r_last : req1_valid;
      end
      S_XFER: begin
        w_rise      = w_half_tc & ~r_sclk;
        w_fall      = w_half_tc & r_sclk;
        w_xfer_done = w_fall && (r_half == 7'd127);
      end
      S_GAP:   w_gap_done = (r_gcnt == GAP_TC);
      default: ;
    endcase
    w_grant_addr = (w_grant_port ? req1_addr : req0_addr) & ~24'h3;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_last  <= 1'b1;
      r_port  <= 1'b0;
      r_sclk  <= 1'b0;
      r_csb   <= 1'b1;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
      r_hcnt  <= '0;
      r_half  <= '0;
      r_gcnt  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_hcnt <= '0;
          r_half <= '0;
          r_gcnt <= '0;
          r_sclk <= 1'b0;
          if (w_grant) begin
            r_port <= w_grant_port;
            r_last <= w_grant_port;
            r_busy <= 1'b1;
            r_csb  <= 1'b0;
            r_tx   <= {CMD_READ, w_grant_addr};
          end
        end
        S_XFER: begin
          r_hcnt <= w_half_tc ? '0 : r_hcnt + 1'b1;
          if (w_half_tc) begin
            r_sclk <= ~r_sclk;
            r_half <= r_half + 1'b1;
          end
          // The shifter keeps only the last 32 samples, i.e. the data phase.
          if (w_rise) r_rx <= {r_rx[30:0], flash_io1};
          if (w_fall) r_tx <= {r_tx[30:0], 1'b0};
          if (w_xfer_done) begin
            r_csb   <= 1'b1;
            r_rdata <= w_word;
            r_ack0  <= ~r_port;
            r_ack1  <= r_port;
          end
        end
        S_GAP: begin
          r_gcnt <= r_gcnt + 1'b1;
          if (w_gap_done) r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req0_ack  = r_ack0;
  assign req1_ack  = r_ack1;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign flash_csb = r_csb;
  assign flash_clk = r_sclk;
  assign flash_io0 = r_tx[31];
endmodule
